serial_tx: RTL and testbench
============================

# serial_tx

Parameterised serial frame transmitter. It accepts a parallel word through a valid/ready handshake and shifts it out on a single line: start bit, data bits LSB first, optional even parity, then stop bit. It is the transmit end of the team's flip-flop-based serial receive chain, and it drives that chain's `d` input one bit period at a time.

## Interface
Parameters:
- `WIDTH`, default 8: data word width; must be ≥ 1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥ 1.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `r`, input, 1: reset, asynchronous, active-high.
- `din`, input, `WIDTH`: word to transmit; sampled only on the accept edge.
- `valid`, input, 1: `din` is valid.
- `ready`, output, 1: block can accept a word. Combinational, equal to (state == IDLE).
- `sd`, output, 1: serial line, registered. Idles high.
- `busy`, output, 1: registered; high from the accept edge until the last stop-bit cycle ends.
- `done`, output, 1: registered one-cycle pulse in the first IDLE cycle after a completed frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: a word is accepted on a rising edge with `valid` && `ready`.
  - On that edge `din` is copied to the shift register.
  - Parity is latched as XOR of `din`.
  - Bit index is set to 0, state moves to START, and `sd` goes to 0.
- `valid` while not ready is ignored. No queuing, no error flag.
- Bit timer counts 0..`CLKS_PER_BIT`-1. A tick occurs at terminal count, and the timer reloads to 0 on each state change.
- On each tick, state transitions and `sd` updates as follows:
  - START → DATA, `sd` = shift_reg[0].
  - DATA: shift right and increment index. After bit `WIDTH`-1, go to PARITY (with `sd` = parity) if `PARITY_EN`, else to STOP (with `sd` = 1).
  - PARITY → STOP, `sd` = 1.
  - STOP → IDLE, with `done` asserted for one cycle.
- Each bit is held on `sd` for exactly `CLKS_PER_BIT` cycles.
- Parity is even: the data bits plus the parity bit together contain an even number of ones.
- Width rules:
  - Bit index is $clog2(`WIDTH`+1) bits.
  - Bit timer is $clog2(`CLKS_PER_BIT`+1) bits, and must not wrap before terminal count.
- Reset (any time, including mid-frame): the frame is abandoned at once.
  - State = IDLE, `sd` = 1, `busy` = 0, `done` = 0.
  - Shift register, index and timer are cleared, so `ready` = 1.
  - No `done` is issued for an abandoned frame.
- Back-to-back: `ready` is high in the `done` cycle. A word offered then is accepted, so the idle gap between frames is exactly 1 cycle.

## Timing
- Latency from accept edge to start bit on `sd`: 0 cycles. The start bit appears on the accept edge itself.
- Frame length on `sd`: F = (`WIDTH` + 2 + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
- `done` rises F cycles after the accept edge.
- Minimum accept-to-accept period: F + 1 cycles.
- `busy` is high for exactly F cycles per frame.
- `CLKS_PER_BIT` = 1: a tick occurs every cycle, and the timer stays at 0.

## Structure
- Package `serial_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `SD_IDLE` = 1'b1, `SD_START` = 1'b0, `SD_STOP` = 1'b1.
- Sub-module `bit_timer`:
  - parameter `CLKS_PER_BIT`;
  - ports `clk`, `r`, `clr`, `tick`;
  - a modulo counter that emits `tick` at terminal count.
- The FSM, shift register and parity live in `serial_tx`.

## Test plan
All scenarios use `WIDTH`=8, `CLKS_PER_BIT`=4, `PARITY_EN`=1 unless stated.
- Reset and idle: assert `r` for 3 cycles, then release → `sd`=1, `busy`=0, `done`=0, `ready`=1. Output holds with `valid`=0.
- Single frame, `din`=8'hA5: `sd` carries 0,1,0,1,0,0,1,0,1,0,1, each for 4 cycles (44 cycles in total). `done` pulses at cycle 44 after accept.
- Parity on `din`=8'h01: parity bit = 1. With `PARITY_EN`=0 the frame is 40 cycles, with no parity slot.
- Busy ignore: pulse `valid` with 8'hFF at cycle 10 of an 8'h3C frame → 8'h3C is sent intact, and 8'hFF is never transmitted.
- Back-to-back: hold `valid` high with 8'h55 then 8'hAA → the second start bit begins exactly 45 cycles after the first accept. Two `done` pulses.
- Reset mid-frame: assert `r` at cycle 17 of an 8'hC3 frame → `sd`=1 asynchronously, with no `done`. The next accepted frame 8'h0F is transmitted correctly.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and line-level constants for the serial
//                frame transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Transmitter frame phases.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Serial line levels.
    localparam logic SD_IDLE  = 1'b1;
    localparam logic SD_START = 1'b0;
    localparam logic SD_STOP  = 1'b1;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_if
//  Description : Word handshake and serial-line bundle for serial_tx.
//                The master side offers words; the slave side (the
//                transmitter) accepts them and drives the line and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             ready;
    logic             sd;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output valid,
        input  ready,
        input  sd,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  valid,
        output ready,
        output sd,
        output busy,
        output done
    );
endinterface : serial_tx_if
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Modulo-CLKS_PER_BIT counter. Raises tick while the count
//                sits at its terminal value; clr forces the count back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic clk,
    input  wire logic r,
    input  wire logic clr,
    output logic      tick
);

    // One extra bit of headroom so the count never wraps before terminal.
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // Next count: reload on clear or terminal count, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : bit_timer
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Serial frame transmitter. Accepts a word over a
//                valid/ready handshake and shifts it out as start bit,
//                data LSB first, optional even parity, stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input wire logic  clk,
    input wire logic  r,
    serial_tx_if.slave bus
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_nxt;
    logic [IW-1:0]    idx_q, idx_d;
    logic             par_q, par_d;
    logic             sd_q, sd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             timer_clr;

    // The timer is held at zero while idle so the start bit gets a full
    // period; every later state change coincides with a tick, which
    // reloads the timer by itself.
    assign timer_clr = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .r    (r),
        .clr  (timer_clr),
        .tick (tick)
    );

    assign shift_nxt = shift_q >> 1;

    assign bus.ready = (state_q == IDLE);
    assign bus.sd    = sd_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        sd_d    = sd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    shift_d = bus.din;
                    par_d   = ^bus.din;
                    idx_d   = '0;
                    state_d = START;
                    sd_d    = SD_START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    sd_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_nxt;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            sd_d    = par_q;
                        end else begin
                            state_d = STOP;
                            sd_d    = SD_STOP;
                        end
                    end else begin
                        sd_d = shift_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    sd_d    = SD_STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    sd_d    = SD_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sd_d    = SD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            sd_q    <= SD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            sd_q    <= sd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule : serial_tx
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Scoreboard bench for serial_tx. Two instances share one
//                stimulus stream: A (8 bits, 4 clk/bit, parity) and
//                B (8 bits, 1 clk/bit, no parity). Accepted words are
//                expanded into per-cycle expected line/status values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    localparam int W     = 8;
    localparam int CPB_A = 4;
    localparam int PAR_A = 1;
    localparam int CPB_B = 1;
    localparam int PAR_B = 0;
    localparam int F_A   = (W + 2 + PAR_A) * CPB_A;
    localparam int F_B   = (W + 2 + PAR_B) * CPB_B;

    typedef struct packed {
        logic sd;
        logic busy;
        logic done;
        logic ready;
    } exp_t;
    typedef exp_t exq_t[$];

    logic         clk   = 1'b0;
    logic         r     = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] din   = '0;

    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   free_a = 0;
    int   free_b = 0;
    exq_t qa;
    exq_t qb;

    serial_tx_if #(.WIDTH(W)) bus_a ();
    serial_tx_if #(.WIDTH(W)) bus_b ();

    assign bus_a.valid = valid;
    assign bus_a.din   = din;
    assign bus_b.valid = valid;
    assign bus_b.din   = din;

    serial_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB_A),
        .PARITY_EN    (PAR_A)
    ) dut_a (
        .clk (clk),
        .r   (r),
        .bus (bus_a)
    );

    serial_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB_B),
        .PARITY_EN    (PAR_B)
    ) dut_b (
        .clk (clk),
        .r   (r),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    function automatic exp_t idle_exp();
        exp_t e;
        e.sd    = 1'b1;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Reference: a frame is the bit list start, data LSB first, optional
    // even parity, stop; each bit lasts cpb cycles, then one done cycle.
    function automatic exq_t expand(input logic [W-1:0] d, input int cpb, input int par_en);
        exq_t   o;
        logic   bits[$];
        exp_t   e;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (par_en != 0) bits.push_back(($countones(d) % 2) == 1);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j < cpb; j++) begin
                e.sd    = bits[i];
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.ready = 1'b0;
                o.push_back(e);
            end
        end
        e.sd    = 1'b1;
        e.busy  = 1'b0;
        e.done  = 1'b1;
        e.ready = 1'b1;
        o.push_back(e);
        return o;
    endfunction

    function automatic void chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endfunction

    // Acceptance model: a word is taken when valid is seen at an edge at
    // least F+1 cycles after the previous accept and reset is low.
    initial begin : model
        exq_t t;
        forever begin
            @(posedge clk);
            if (!r && valid) begin
                if (cyc >= free_a) begin
                    t = expand(din, CPB_A, PAR_A);
                    foreach (t[i]) qa.push_back(t[i]);
                    free_a = cyc + F_A + 1;
                end
                if (cyc >= free_b) begin
                    t = expand(din, CPB_B, PAR_B);
                    foreach (t[i]) qb.push_back(t[i]);
                    free_b = cyc + F_B + 1;
                end
            end
            cyc++;
        end
    end

    // Monitor for instance A.
    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            e = idle_exp();
            if (qa.size() > 0) e = qa.pop_front();
            chk("A.sd",    bus_a.sd,    e.sd);
            chk("A.busy",  bus_a.busy,  e.busy);
            chk("A.done",  bus_a.done,  e.done);
            chk("A.ready", bus_a.ready, e.ready);
        end
    end

    // Monitor for instance B.
    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            e = idle_exp();
            if (qb.size() > 0) e = qb.pop_front();
            chk("B.sd",    bus_b.sd,    e.sd);
            chk("B.busy",  bus_b.busy,  e.busy);
            chk("B.done",  bus_b.done,  e.done);
            chk("B.ready", bus_b.ready, e.ready);
        end
    end

    task automatic cycle_in(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        valid = v;
        din   = d;
    endtask

    task automatic idle_for(input int n);
        for (int i = 0; i < n; i++) cycle_in(1'b0, din);
    endtask

    task automatic async_reset();
        #2;
        r = 1'b1;
        qa.delete();
        qb.delete();
        free_a = 0;
        free_b = 0;
        #1;
        chk("rst.A.sd",    bus_a.sd,    1'b1);
        chk("rst.A.busy",  bus_a.busy,  1'b0);
        chk("rst.A.done",  bus_a.done,  1'b0);
        chk("rst.A.ready", bus_a.ready, 1'b1);
        chk("rst.B.sd",    bus_b.sd,    1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        r = 1'b0;
    endtask

    initial begin : stim
        #1;
        r = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        r = 1'b0;
        idle_for(5);

        // Single frames, including a one-hot word for the parity slot.
        cycle_in(1'b1, 8'hA5);
        idle_for(50);
        cycle_in(1'b1, 8'h01);
        idle_for(50);

        // Word offered mid-frame must be dropped.
        cycle_in(1'b1, 8'h3C);
        idle_for(9);
        cycle_in(1'b1, 8'hFF);
        idle_for(50);

        // Valid held high: second word taken right after the done cycle.
        cycle_in(1'b1, 8'h55);
        for (int i = 0; i < F_A + 1; i++) cycle_in(1'b1, 8'hAA);
        idle_for(50);

        // Reset in the middle of a frame, then a clean frame.
        cycle_in(1'b1, 8'hC3);
        idle_for(18);
        async_reset();
        idle_for(3);
        cycle_in(1'b1, 8'h0F);
        idle_for(50);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle_in(($urandom % 3) == 0, 8'($urandom));
        end
        idle_for(1);

        for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0); i++) begin
            @(negedge clk);
        end
        total++;
        if (qa.size() > 0 || qb.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d pending want=0", qa.size(), qb.size());
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_tx
`default_nettype wire
